// File: rtl/key_pkg.sv
// Shared constants and state encoding for the debounced-key event decoder.
package key_pkg;

    localparam int C_LONG_NUM_DEF   = 50_000_000;  // 0.5 s at 100 MHz
    localparam int C_REPEAT_NUM_DEF = 10_000_000;  // 0.1 s at 100 MHz
    localparam int C_CNT_W_DEF      = 26;

    typedef enum logic [1:0] {
        ST_LOCK  = 2'd0,
        ST_IDLE  = 2'd1,
        ST_PRESS = 2'd2,
        ST_LONG  = 2'd3
    } key_state_t;

endpackage

// File: rtl/hold_timer.sv
// Hold-time counter with synchronous clear, increment enable and a terminal-count
// flag against a limit that the owner may switch at run time.
module hold_timer
    import key_pkg::*;
#(
    parameter int C_CNT_W = C_CNT_W_DEF
) (
    input  logic               I_clk,
    input  logic               I_rst,
    input  logic               I_clr,
    input  logic               I_inc,
    input  logic [C_CNT_W-1:0] I_limit,
    output logic               O_tc
);

    logic [C_CNT_W-1:0] cnt;

    always_ff @(posedge I_clk) begin
        if (I_rst || I_clr) begin
            cnt <= '0;
        end else if (I_inc) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign O_tc = (cnt == I_limit);

endmodule

// File: rtl/key_event_decoder.sv
// Turns a clean, synchronous key level into press/release/click/long/repeat
// pulses plus a held level and a running click count.
module key_event_decoder
    import key_pkg::*;
#(
    parameter int C_LONG_NUM   = C_LONG_NUM_DEF,
    parameter int C_REPEAT_NUM = C_REPEAT_NUM_DEF,
    parameter int C_REPEAT_EN  = 1,
    parameter int C_ACTIVE_LVL = 1,
    parameter int C_CNT_W      = C_CNT_W_DEF
) (
    input  logic       I_clk,
    input  logic       I_rst,
    input  logic       I_key_in,
    output logic       O_press,
    output logic       O_release,
    output logic       O_click,
    output logic       O_long,
    output logic       O_repeat,
    output logic       O_held,
    output logic [7:0] O_click_cnt,
    output logic [1:0] O_dbg_state
);

    key_state_t         state;
    logic               act;
    logic               tmr_clr;
    logic               tmr_inc;
    logic               tmr_tc;
    logic [C_CNT_W-1:0] tmr_limit;

    assign act         = (I_key_in == 1'(C_ACTIVE_LVL));
    assign O_dbg_state = state;

    // One counter serves both thresholds; the limit follows the current state.
    assign tmr_limit = (state == ST_LONG) ? C_CNT_W'(C_REPEAT_NUM - 1)
                                          : C_CNT_W'(C_LONG_NUM - 1);

    always_comb begin
        tmr_clr = 1'b1;
        tmr_inc = 1'b0;
        case (state)
            ST_PRESS: begin
                if (act && !tmr_tc) begin
                    tmr_clr = 1'b0;
                    tmr_inc = 1'b1;
                end
            end
            ST_LONG: begin
                if (act) begin
                    if (!tmr_tc) begin
                        tmr_clr = 1'b0;
                        tmr_inc = 1'b1;
                    end else if (C_REPEAT_EN == 0) begin
                        tmr_clr = 1'b0;  // park at the limit when repeat is off
                    end
                end
            end
            default: ;
        endcase
    end

    hold_timer #(
        .C_CNT_W (C_CNT_W)
    ) u_hold_timer (
        .I_clk   (I_clk),
        .I_rst   (I_rst),
        .I_clr   (tmr_clr),
        .I_inc   (tmr_inc),
        .I_limit (tmr_limit),
        .O_tc    (tmr_tc)
    );

    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            state       <= ST_LOCK;
            O_press     <= 1'b0;
            O_release   <= 1'b0;
            O_click     <= 1'b0;
            O_long      <= 1'b0;
            O_repeat    <= 1'b0;
            O_held      <= 1'b0;
            O_click_cnt <= '0;
        end else begin
            O_press   <= 1'b0;
            O_release <= 1'b0;
            O_click   <= 1'b0;
            O_long    <= 1'b0;
            O_repeat  <= 1'b0;
            case (state)
                ST_LOCK: begin
                    O_held <= 1'b0;
                    if (!act) state <= ST_IDLE;
                end
                ST_IDLE: begin
                    O_held <= act;
                    if (act) begin
                        state   <= ST_PRESS;
                        O_press <= 1'b1;
                    end
                end
                ST_PRESS: begin
                    // Release takes priority over reaching the long threshold.
                    if (!act) begin
                        state       <= ST_IDLE;
                        O_held      <= 1'b0;
                        O_release   <= 1'b1;
                        O_click     <= 1'b1;
                        O_click_cnt <= O_click_cnt + 8'd1;
                    end else if (tmr_tc) begin
                        state  <= ST_LONG;
                        O_long <= 1'b1;
                    end
                end
                ST_LONG: begin
                    if (!act) begin
                        state     <= ST_IDLE;
                        O_held    <= 1'b0;
                        O_release <= 1'b1;
                    end else if ((C_REPEAT_EN != 0) && tmr_tc) begin
                        O_repeat <= 1'b1;
                    end
                end
                default: begin
                    state  <= ST_LOCK;
                    O_held <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_key_event_decoder.sv
// Bench for key_event_decoder: a table of hand-derived vectors, corner sequences,
// and random key activity checked against an event-level reference model.
module tb_key_event_decoder;

    localparam int L = 8;
    localparam int R = 4;

    typedef struct packed {
        logic       press;
        logic       rel;
        logic       click;
        logic       lng;
        logic       rpt;
        logic       held;
        logic [7:0] cnt;
    } obs_t;

    typedef struct {
        bit   r;
        bit   k;
        obs_t e;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       key = 1'b0;
    logic       key_b;
    logic       a_press, a_rel, a_click, a_lng, a_rpt, a_held;
    logic       b_press, b_rel, b_click, b_lng, b_rpt, b_held;
    logic [7:0] a_cnt, b_cnt;
    logic [1:0] a_state, b_state;
    obs_t       a_obs, b_obs;

    assign key_b = ~key;
    assign a_obs = {a_press, a_rel, a_click, a_lng, a_rpt, a_held, a_cnt};
    assign b_obs = {b_press, b_rel, b_click, b_lng, b_rpt, b_held, b_cnt};

    always #5 clk = ~clk;

    key_event_decoder #(
        .C_LONG_NUM(L), .C_REPEAT_NUM(R), .C_REPEAT_EN(1), .C_ACTIVE_LVL(1), .C_CNT_W(8)
    ) u_dut_a (
        .I_clk(clk), .I_rst(rst), .I_key_in(key),
        .O_press(a_press), .O_release(a_rel), .O_click(a_click), .O_long(a_lng),
        .O_repeat(a_rpt), .O_held(a_held), .O_click_cnt(a_cnt), .O_dbg_state(a_state)
    );

    // Second instance: repeat disabled and active-low key, fed the inverted level.
    key_event_decoder #(
        .C_LONG_NUM(L), .C_REPEAT_NUM(R), .C_REPEAT_EN(0), .C_ACTIVE_LVL(0), .C_CNT_W(8)
    ) u_dut_b (
        .I_clk(clk), .I_rst(rst), .I_key_in(key_b),
        .O_press(b_press), .O_release(b_rel), .O_click(b_click), .O_long(b_lng),
        .O_repeat(b_rpt), .O_held(b_held), .O_click_cnt(b_cnt), .O_dbg_state(b_state)
    );

    // Reference model: tracks how long the key has been held since the press
    // edge and derives each event from that elapsed time.
    bit         m_armed [2];
    bit         m_held  [2];
    int         m_t     [2];
    logic [7:0] m_clicks[2];
    obs_t       m_exp   [2];

    int n_vec = 0;
    int n_bad = 0;
    int a_long_n, a_rpt_n, b_long_n, b_rpt_n;
    vec_t tbl[$];

    task automatic model_step(input int i, input bit r, input bit act, input bit rep_en);
        obs_t o;
        o = '0;
        if (r) begin
            m_armed[i]  = 0;
            m_held[i]   = 0;
            m_t[i]      = 0;
            m_clicks[i] = 8'd0;
        end else if (!m_armed[i]) begin
            if (!act) m_armed[i] = 1;
        end else if (!m_held[i]) begin
            if (act) begin
                m_held[i] = 1;
                m_t[i]    = 0;
                o.press   = 1'b1;
            end
        end else begin
            m_t[i] = m_t[i] + 1;
            if (!act) begin
                o.rel     = 1'b1;
                m_held[i] = 0;
                if (m_t[i] <= L) begin
                    o.click     = 1'b1;
                    m_clicks[i] = m_clicks[i] + 8'd1;
                end
            end else if (m_t[i] == L) begin
                o.lng = 1'b1;
            end else if (rep_en && m_t[i] > L && ((m_t[i] - L) % R) == 0) begin
                o.rpt = 1'b1;
            end
        end
        o.held   = m_held[i];
        o.cnt    = m_clicks[i];
        m_exp[i] = o;
    endtask

    task automatic check(input string name, input obs_t got, input obs_t want);
        n_vec++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s @%0t: got p/r/c/l/rp/h=%b cnt=%0d, expected p/r/c/l/rp/h=%b cnt=%0d",
                     name, $time, got[13:8], got.cnt, want[13:8], want.cnt);
        end
    endtask

    task automatic check_int(input string name, input int got, input int want);
        n_vec++;
        if (got != want) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, got, want);
        end
    endtask

    task automatic step(input bit r, input bit k);
        rst = r;
        key = k;
        @(posedge clk);
        model_step(0, r, k, 1'b1);
        model_step(1, r, k, 1'b0);
        #1;
        check("dut_a_model", a_obs, m_exp[0]);
        check("dut_b_model", b_obs, m_exp[1]);
        a_long_n += int'(a_lng);
        a_rpt_n  += int'(a_rpt);
        b_long_n += int'(b_lng);
        b_rpt_n  += int'(b_rpt);
    endtask

    task automatic add(input bit r, input bit k, input bit p, input bit rl, input bit c,
                       input bit h, input int cnt);
        vec_t v;
        v.r = r;
        v.k = k;
        v.e = {p, rl, c, 1'b0, 1'b0, h, 8'(cnt)};
        tbl.push_back(v);
    endtask

    task automatic clear_pulse_counts();
        a_long_n = 0;
        a_rpt_n  = 0;
        b_long_n = 0;
        b_rpt_n  = 0;
    endtask

    initial begin
        clear_pulse_counts();

        // Short click of 3 cycles after a clean reset.
        add(1, 0, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0);
        add(0, 1, 1, 0, 0, 1, 0);
        add(0, 1, 0, 0, 0, 1, 0);
        add(0, 1, 0, 0, 0, 1, 0);
        add(0, 0, 0, 1, 1, 0, 1);
        add(0, 0, 0, 0, 0, 0, 1);
        // Release exactly on the long-threshold edge: click, never long.
        add(0, 1, 1, 0, 0, 1, 1);
        for (int i = 0; i < L - 1; i++) add(0, 1, 0, 0, 0, 1, 1);
        add(0, 0, 0, 1, 1, 0, 2);
        // Single-cycle active level.
        add(0, 1, 1, 0, 0, 1, 2);
        add(0, 0, 0, 1, 1, 0, 3);
        add(0, 0, 0, 0, 0, 0, 3);
        // Key held through reset: locked until released, then a fresh press.
        add(1, 1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 10; i++) add(0, 1, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0);
        add(0, 1, 1, 0, 0, 1, 0);
        add(0, 0, 0, 1, 1, 0, 1);

        foreach (tbl[i]) begin
            step(tbl[i].r, tbl[i].k);
            check("table", a_obs, tbl[i].e);
            if (i == 0) check_int("reset_state_lock", int'(a_state), int'(key_pkg::ST_LOCK));
        end

        // Long hold of 20 cycles, release at k+21: long at 8, repeats at 12/16/20.
        step(0, 0);
        clear_pulse_counts();
        step(0, 1);
        for (int j = 1; j <= 20; j++) begin
            step(0, 1);
            check_int($sformatf("long_at_k+%0d", j), int'(a_lng), int'(j == L));
            check_int($sformatf("repeat_at_k+%0d", j), int'(a_rpt),
                      int'(j == 12 || j == 16 || j == 20));
        end
        step(0, 0);
        check_int("long_release_rel", int'(a_rel), 1);
        check_int("long_release_no_click", int'(a_click), 0);
        check_int("long_release_cnt", int'(a_cnt), 1);
        check_int("b_repeat_count", b_rpt_n, 0);

        // Reset during LONG at k+10, then release: no release event.
        step(0, 1);
        for (int j = 1; j < 10; j++) step(0, 1);
        step(1, 1);
        check("reset_mid_long", a_obs, obs_t'(0));
        step(0, 1);
        step(0, 1);
        step(0, 0);
        check_int("no_release_after_reset", int'(a_rel), 0);

        // Randomized key activity with occasional resets.
        for (int run = 0; run < 300; run++) begin
            bit k;
            bit r;
            int len;
            k   = 1'($urandom_range(0, 1));
            r   = ($urandom_range(0, 40) == 0);
            len = $urandom_range(1, 3 * L);
            if (r) step(1, k);
            for (int j = 0; j < len; j++) step(0, k);
        end

        // 256 short clicks wrap the counter back to zero.
        step(1, 0);
        step(0, 0);
        for (int i = 0; i < 256; i++) begin
            step(0, 1);
            step(0, 0);
            if (i == 254) check_int("click_cnt_255", int'(a_cnt), 255);
        end
        check_int("click_cnt_wrap_a", int'(a_cnt), 0);
        check_int("click_cnt_wrap_b", int'(b_cnt), 0);

        // 30-cycle hold: repeat-disabled instance gives one long and no repeats.
        clear_pulse_counts();
        step(0, 1);
        for (int j = 0; j < 30; j++) step(0, 1);
        step(0, 0);
        check_int("norepeat_long_count", b_long_n, 1);
        check_int("norepeat_repeat_count", b_rpt_n, 0);
        check_int("repeat_long_count", a_long_n, 1);
        check_int("repeat_repeat_count", a_rpt_n, 5);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
